// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: memory-side responder for a RISC-V core's fetch and data ports.
// An internal array of 2^ADDR_WIDTH 32-bit words serves instruction fetches and data
// loads/stores. Reads are captured on posedge clk and stores commit on negedge clk,
// so a store is visible to a read at the next posedge. After reset, a clear state
// machine zeroes the array and holds the core off. Sticky flags report misaligned and
// out-of-range accesses.
// Optional feature macro: MEM_ACCESS_COUNT_EN adds load_count/store_count outputs.
// BASE_ADDR must be 4-byte aligned. The word index is (addr - BASE_ADDR) >> 2, taken
// modulo 2^32, so addresses below BASE_ADDR wrap to huge offsets and are out of range.

module riscv_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  input  logic [31:0] data_addr,
  input  logic        should_read_mem,
  input  logic        should_write_mem,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        hold,
  input  logic        err_clear,
  output logic        misalign_err,
  output logic        oob_err
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  // Byte offset of an address from the start of the array, wrapping modulo 2^32.
  function automatic logic [31:0] byteOffset(input logic [31:0] addr);
    return addr - BASE_ADDR;
  endfunction

  // Word index inside the array; the low two address bits are dropped, so a
  // misaligned address selects its enclosing aligned word.
  function automatic logic [ADDR_WIDTH-1:0] wordIndex(input logic [31:0] addr);
    return ADDR_WIDTH'(byteOffset(addr) >> 2);
  endfunction

  // True when the byte offset lies below 4 * 2^ADDR_WIDTH.
  function automatic logic inRange(input logic [31:0] addr);
    return (byteOffset(addr) >> (ADDR_WIDTH + 2)) == 32'd0;
  endfunction

  // True when the address is not word aligned.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Storage array. Deliberately has no reset; the clear state machine zeroes it.
  logic [31:0] mem [DEPTH];

  // Control state, updated on the falling edge together with the array writes.
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clearCnt_q, clearCnt_d;
  logic                  misalign_q, misalign_d;
  logic                  oob_q, oob_d;

  // Registered read results, captured on the rising edge.
  logic [31:0] instr_q;
  logic [31:0] readData_q;

  // Array write port, chosen by the state machine.
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memWaddr;
  logic [31:0]           memWdata;

  // Decoded address properties of both ports.
  logic                  fetchInRange, fetchMisaligned;
  logic                  dataInRange, dataMisaligned;
  logic [ADDR_WIDTH-1:0] fetchIdx, dataIdx;
  logic                  dataAccess;
  logic                  storeOk;
  logic                  setMisalign, setOob;
  logic                  running;

  // Address decode for the fetch and data ports and the per-cycle error sources.
  always_comb begin
    fetchIdx        = wordIndex(instr_addr);
    fetchInRange    = inRange(instr_addr);
    fetchMisaligned = misaligned(instr_addr);
    dataIdx         = wordIndex(data_addr);
    dataInRange     = inRange(data_addr);
    dataMisaligned  = misaligned(data_addr);
    dataAccess      = should_read_mem | should_write_mem;
    storeOk         = should_write_mem & dataInRange & ~dataMisaligned;
    setMisalign     = fetchMisaligned | (dataAccess & dataMisaligned);
    setOob          = ~fetchInRange | (dataAccess & ~dataInRange);
    running         = (state_q == StRun);
  end

  // Next-state logic: the INIT sweep writes zeros, RUN commits stores and tracks errors.
  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    misalign_d = misalign_q;
    oob_d      = oob_q;
    memWe      = 1'b0;
    memWaddr   = clearCnt_q;
    memWdata   = 32'd0;
    case (state_q)
      StInit: begin
        memWe      = 1'b1;
        memWaddr   = clearCnt_q;
        memWdata   = 32'd0;
        clearCnt_d = clearCnt_q + ADDR_WIDTH'(1);
        if (&clearCnt_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        memWe    = storeOk;
        memWaddr = dataIdx;
        memWdata = mem_write_data;
        if (err_clear) begin
          misalign_d = setMisalign;
          oob_d      = setOob;
        end else begin
          misalign_d = misalign_q | setMisalign;
          oob_d      = oob_q | setOob;
        end
      end
      default: begin
        state_d    = StInit;
        clearCnt_d = '0;
      end
    endcase
  end

  // Falling-edge control registers; reset restarts the clear sweep from word 0.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      clearCnt_q <= '0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
      misalign_q <= misalign_d;
      oob_q      <= oob_d;
    end
  end

  // Falling-edge array write; while reset is held this only rewrites word 0 with zero.
  always_ff @(negedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  // Rising-edge fetch and load capture; out-of-range reads return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= NOP_INSTR;
      readData_q <= 32'd0;
    end else if (running) begin
      instr_q <= fetchInRange ? mem[fetchIdx] : 32'd0;
      if (should_read_mem) begin
        readData_q <= dataInRange ? mem[dataIdx] : 32'd0;
      end
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] loadCount_q;
  logic [31:0] storeCount_q;

  // Count loads accepted on the rising edge while running; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loadCount_q <= 32'd0;
    end else if (running && should_read_mem) begin
      loadCount_q <= loadCount_q + 32'd1;
    end
  end

  // Count only stores that actually commit to the array; dropped stores are ignored.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      storeCount_q <= 32'd0;
    end else if (running && storeOk) begin
      storeCount_q <= storeCount_q + 32'd1;
    end
  end

  assign load_count  = loadCount_q;
  assign store_count = storeCount_q;
`endif

  assign instr         = instr_q;
  assign mem_read_data = readData_q;
  assign hold          = (state_q == StInit);
  assign misalign_err  = misalign_q;
  assign oob_err       = oob_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Testbench for riscv_mem_responder with ADDR_WIDTH=4 and BASE_ADDR=32'h100.
// Inputs change 1 time unit after a falling edge; each cycle then sees one rising
// edge (reads) and one falling edge (stores, flags), and outputs are sampled 1 time
// unit after that falling edge.

module tb_riscv_mem_responder;

  localparam int unsigned AW   = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic [31:0] data_addr;
  logic        should_read_mem;
  logic        should_write_mem;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        hold;
  logic        err_clear;
  logic        misalign_err;
  logic        oob_err;
`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] load_count;
  logic [31:0] store_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instrAddr;
    logic [31:0] dataAddr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        errClr;
    logic [31:0] expInstr;
    logic [31:0] expRdata;
    logic        expMis;
    logic        expOob;
  } vec_t;

  vec_t vecs [18];
  vec_t post [5];

  riscv_mem_responder #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_addr      (instr_addr),
    .instr           (instr),
    .data_addr       (data_addr),
    .should_read_mem (should_read_mem),
    .should_write_mem(should_write_mem),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .hold            (hold),
    .err_clear       (err_clear),
    .misalign_err    (misalign_err),
    .oob_err         (oob_err)
`ifdef MEM_ACCESS_COUNT_EN
    ,
    .load_count      (load_count),
    .store_count     (store_count)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, lets a rising and a falling edge pass, then waits 1 unit.
  task automatic applyStimulus(input vec_t v);
    instr_addr       = v.instrAddr;
    data_addr        = v.dataAddr;
    should_read_mem  = v.rd;
    should_write_mem = v.wr;
    mem_write_data   = v.wdata;
    err_clear        = v.errClr;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput($sformatf("%s.instr", tag), instr, v.expInstr);
    checkOutput($sformatf("%s.rdata", tag), mem_read_data, v.expRdata);
    checkOutput($sformatf("%s.misalign", tag), {31'd0, misalign_err}, {31'd0, v.expMis});
    checkOutput($sformatf("%s.oob", tag), {31'd0, oob_err}, {31'd0, v.expOob});
    checkOutput($sformatf("%s.hold", tag), {31'd0, hold}, 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput($sformatf("%s.instr", tag), instr, NOP);
    checkOutput($sformatf("%s.rdata", tag), mem_read_data, 32'd0);
    checkOutput($sformatf("%s.hold", tag), {31'd0, hold}, 32'd1);
    checkOutput($sformatf("%s.misalign", tag), {31'd0, misalign_err}, 32'd0);
    checkOutput($sformatf("%s.oob", tag), {31'd0, oob_err}, 32'd0);
  endtask

  // Releases reset just after a falling edge and walks the full 16-edge clear,
  // with hostile requests on the ports that must all be ignored.
  task automatic runInit(input string tag);
    @(negedge clk);
    #1;
    instr_addr       = 32'h0000_0106;
    data_addr        = 32'h0000_0200;
    should_read_mem  = 1'b1;
    should_write_mem = 1'b1;
    mem_write_data   = 32'hFFFF_FFFF;
    err_clear        = 1'b0;
    reset            = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("%s.hold%0d", tag, i), {31'd0, hold}, (i < 16) ? 32'd1 : 32'd0);
      checkOutput($sformatf("%s.instr%0d", tag, i), instr, NOP);
      checkOutput($sformatf("%s.rdata%0d", tag, i), mem_read_data, 32'd0);
    end
    checkOutput($sformatf("%s.misalign", tag), {31'd0, misalign_err}, 32'd0);
    checkOutput($sformatf("%s.oob", tag), {31'd0, oob_err}, 32'd0);
  endtask

  initial begin
    // ia, da, rd, wr, wdata, clr, expInstr, expRdata, expMis, expOob
    vecs[0]  = '{32'h100, 32'h13C, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{32'h100, 32'h104, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[2]  = '{32'h104, 32'h104, 1'b1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{32'h100, 32'h106, 1'b0, 1'b1, 32'h1,        1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[4]  = '{32'h104, 32'h106, 1'b1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[5]  = '{32'h100, 32'h104, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[6]  = '{32'h100, 32'h105, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[7]  = '{32'h100, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[8]  = '{32'h0FC, 32'h140, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[9]  = '{32'h100, 32'h140, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[10] = '{32'h13C, 32'h100, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[11] = '{32'h108, 32'h108, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[12] = '{32'h104, 32'h108, 1'b1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0};
    vecs[13] = '{32'h100, 32'h141, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[14] = '{32'h100, 32'h10A, 1'b0, 1'b1, 32'hFFFF,     1'b1, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[15] = '{32'h100, 32'h108, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h12345678, 1'b0, 1'b0};
    vecs[16] = '{32'h107, 32'h108, 1'b0, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0};
    vecs[17] = '{32'h100, 32'h0FF, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h12345678, 1'b0, 1'b0};

    // After the mid-INIT reset: array must be clear again; 3 loads, 2 good stores, 1 dropped.
    post[0]  = '{32'h104, 32'h104, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    post[1]  = '{32'h100, 32'h108, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    post[2]  = '{32'h100, 32'h10C, 1'b1, 1'b1, 32'h55,       1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    post[3]  = '{32'h100, 32'h110, 1'b0, 1'b1, 32'h66,       1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
    post[4]  = '{32'h10C, 32'h111, 1'b0, 1'b1, 32'h77,       1'b0, 32'h55,       32'h0,        1'b1, 1'b0};

    reset            = 1'b0;
    instr_addr       = 32'h100;
    data_addr        = 32'h100;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
    mem_write_data   = 32'h0;
    err_clear        = 1'b0;
    #22;
    checkResetState("reset");
`ifdef MEM_ACCESS_COUNT_EN
    checkOutput("reset.loadCount", load_count, 32'd0);
    checkOutput("reset.storeCount", store_count, 32'd0);
`endif

    runInit("init1");

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkVector($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the middle of RUN, then again at INIT count 5.
    #1;
    reset = 1'b0;
    #1;
    checkResetState("rstRun");
    runInit("partial_unused");
    // runInit finished a full clear; now restart and interrupt after 5 edges.
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("mid.hold%0d", i), {31'd0, hold}, 32'd1);
    end
    reset = 1'b0;
    #1;
    checkResetState("rstMidInit");
    runInit("init2");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(post[i]);
      checkVector($sformatf("p%0d", i), post[i]);
    end
`ifdef MEM_ACCESS_COUNT_EN
    checkOutput("count.load", load_count, 32'd3);
    checkOutput("count.store", store_count, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
